// File: rtl/fcp_master_sequencer.sv
// fcp_master_sequencer
//   Sequences single-byte FCP register read/write transactions over the FCP
//   byte channel. Two requesters (0 = host CSR, 1 = auto-poll) share the
//   channel through a round-robin arbiter. A granted request is sent as
//   CMD/ADDR[/DATA] bytes, then the slave ACK (and read data) is awaited.
//   NACK, a receive error or a timeout causes a full resend after an idle
//   gap, up to MAX_RETRY extra attempts, before a failing completion.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   r_valid/r_wr          per-requester request pending / write(1) read(0)
//   r_addr/r_wdata        {r1,r0} address and write data bytes
//   r_ack                 one-cycle one-hot grant pulse
//   tx_valid/tx_data/tx_ready   byte stream towards the phy
//   rx_valid/rx_data/rx_err     byte stream from the phy
//   busy                  a transaction is in progress
//   done/done_id/status/rdata   one-cycle completion report
module fcp_master_sequencer #(
  parameter logic [7:0] CMD_WR    = 8'h0B,
  parameter logic [7:0] CMD_RD    = 8'h0C,
  parameter logic [7:0] ACK_CODE  = 8'h08,
  parameter logic [7:0] NACK_CODE = 8'h03,
  parameter int         TO_W      = 16,
  parameter int         TIMEOUT   = 5000,
  parameter int         GAP_CYC   = 100,
  parameter int         MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  r_valid,
  input  logic [1:0]  r_wr,
  input  logic [15:0] r_addr,
  input  logic [15:0] r_wdata,
  output logic [1:0]  r_ack,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [1:0]  status,
  output logic [7:0]  rdata
);

  typedef enum logic [2:0] {
    IDLE, TX_CMD, TX_ADDR, TX_DATA, WAIT_ACK, WAIT_DATA, GAP, DONE
  } state_e;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_NACK  = 2'b01;
  localparam logic [1:0] ST_TO    = 2'b10;
  localparam logic [1:0] ST_RXERR = 2'b11;

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] GAP_LAST  = TO_W'(GAP_CYC - 1);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

  state_e          state_q, state_d;
  logic            rrLast_q, rrLast_d;
  logic            wr_q, wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            id_q, id_d;
  logic [2:0]      retry_q, retry_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [1:0] grant;
  logic       grantId;
  logic       failIt;
  logic [1:0] failStatus;

  // Round-robin: on a tie the requester that did not win last time is
  // granted; a lone request is granted directly.
  assign grant   = (r_valid == 2'b11) ? (rrLast_q ? 2'b01 : 2'b10) : r_valid;
  assign grantId = grant[1];

  // State register; rrLast resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rrLast_q <= 1'b1;
      wr_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      id_q     <= 1'b0;
      retry_q  <= 3'd0;
      toCnt_q  <= '0;
      status_q <= ST_OK;
      rdata_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      rrLast_q <= rrLast_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      id_q     <= id_d;
      retry_q  <= retry_d;
      toCnt_q  <= toCnt_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state logic. toCnt is shared by the WAIT_* timeout and the GAP
  // delay; it is cleared whenever one of those states is entered.
  always_comb begin
    state_d    = state_q;
    rrLast_d   = rrLast_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    id_d       = id_q;
    retry_d    = retry_q;
    toCnt_d    = toCnt_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    failIt     = 1'b0;
    failStatus = ST_OK;

    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d  = TX_CMD;
          wr_d     = r_wr[grantId];
          addr_d   = grantId ? r_addr[15:8]  : r_addr[7:0];
          wdata_d  = grantId ? r_wdata[15:8] : r_wdata[7:0];
          id_d     = grantId;
          rrLast_d = grantId;
          retry_d  = 3'd0;
        end
      end
      TX_CMD: begin
        if (tx_ready) state_d = TX_ADDR;
      end
      TX_ADDR: begin
        if (tx_ready) begin
          state_d = wr_q ? TX_DATA : WAIT_ACK;
          toCnt_d = '0;
        end
      end
      TX_DATA: begin
        if (tx_ready) begin
          state_d = WAIT_ACK;
          toCnt_d = '0;
        end
      end
      WAIT_ACK: begin
        // A byte arriving on the last timeout cycle takes precedence.
        if (rx_valid) begin
          if (rx_err) begin
            failIt     = 1'b1;
            failStatus = ST_RXERR;
          end else if (rx_data == ACK_CODE) begin
            if (wr_q) begin
              state_d  = DONE;
              status_d = ST_OK;
            end else begin
              state_d = WAIT_DATA;
              toCnt_d = '0;
            end
          end else if (rx_data == NACK_CODE) begin
            failIt     = 1'b1;
            failStatus = ST_NACK;
          end else begin
            // Unexpected reply bytes are treated like a NACK.
            failIt     = 1'b1;
            failStatus = ST_NACK;
          end
        end else if (toCnt_q == TO_LAST) begin
          failIt     = 1'b1;
          failStatus = ST_TO;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
      end
      WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_err) begin
            failIt     = 1'b1;
            failStatus = ST_RXERR;
          end else begin
            rdata_d  = rx_data;
            state_d  = DONE;
            status_d = ST_OK;
          end
        end else if (toCnt_q == TO_LAST) begin
          failIt     = 1'b1;
          failStatus = ST_TO;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (toCnt_q == GAP_LAST) state_d = TX_CMD;
        else                     toCnt_d = toCnt_q + TO_W'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A failed attempt either schedules a full resend after the gap or,
    // once retries are used up, completes with the failure cause.
    if (failIt) begin
      status_d = failStatus;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 3'd1;
        state_d = GAP;
        toCnt_d = '0;
      end else begin
        state_d = DONE;
      end
    end
  end

  // Outputs decoded from the current state; tx_data depends only on
  // registered values so it stays stable while the phy stalls.
  always_comb begin
    r_ack    = 2'b00;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IDLE: r_ack = grant;
      TX_CMD: begin
        tx_valid = 1'b1;
        tx_data  = wr_q ? CMD_WR : CMD_RD;
      end
      TX_ADDR: begin
        tx_valid = 1'b1;
        tx_data  = addr_q;
      end
      TX_DATA: begin
        tx_valid = 1'b1;
        tx_data  = wdata_q;
      end
      default: ;
    endcase
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    done_id = id_q;
    status  = status_q;
    rdata   = rdata_q;
  end

endmodule
